// File: rtl/rr_arb16_sched.sv
// rr_arb16_sched: round-robin scheduler for one resource shared by 16 requesters.
// Holds each grant until release or hold limit, then rotates priority.
module rr_arb16_sched #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] req,
  output logic        gnt_valid,
  output logic [3:0]  gnt_idx,
  output logic [15:0] gnt_onehot,
  output logic        timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX =
    CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE =
    CNT_W'(1);

  state_t           state;
  state_t           state_n;
  logic [3:0]       ptr;
  logic [3:0]       ptr_n;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_n;
  logic             valid_n;
  logic [3:0]       idx_n;
  logic [15:0]      oh_n;
  logic             to_n;

  logic             drop;
  logic             hit_max;
  logic             rel;
  logic [3:0]       rel_ptr;

  logic [3:0]       arb_ptr;
  logic [15:0]      arb_req;
  logic [15:0]      arb_rot;
  logic [4:0]       arb_lsh;
  logic [3:0]       arb_off;
  logic             arb_any;
  logic [3:0]       arb_win;

  // release conditions for the current holder
  always_comb begin
    drop    = ~req[gnt_idx];
    hit_max = (hold_cnt == HOLD_MAX);
    rel     = drop | hit_max;
    rel_ptr = gnt_idx + 4'd1;
  end

  // rotate requests so the search start lands on bit 0,
  // masking the releasing holder out of the same-cycle pick
  always_comb begin
    if (state == GRANT) begin
      arb_ptr = rel_ptr;
      arb_req = req & ~gnt_onehot;
    end else begin
      arb_ptr = ptr;
      arb_req = req;
    end
    arb_lsh = 5'd16 - {1'b0, arb_ptr};
    arb_rot = (arb_req >> arb_ptr)
            | (arb_req << arb_lsh);
    arb_any = |arb_rot;
    arb_off = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (arb_rot[i]) begin
        arb_off = 4'(i);
      end
    end
    arb_win = arb_ptr + arb_off;
  end

  // next state and next registered outputs
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    valid_n = gnt_valid;
    idx_n   = gnt_idx;
    oh_n    = gnt_onehot;
    to_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && arb_any) begin
          state_n = GRANT;
          valid_n = 1'b1;
          idx_n   = arb_win;
          oh_n    = 16'd1 << arb_win;
          hold_n  = HOLD_ONE;
        end else begin
          valid_n = 1'b0;
          oh_n    = 16'd0;
        end
      end
      GRANT: begin
        unique case (1'b1)
          rel: begin
            ptr_n = rel_ptr;
            to_n  = hit_max & ~drop;
            if (en && arb_any) begin
              valid_n = 1'b1;
              idx_n   = arb_win;
              oh_n    = 16'd1 << arb_win;
              hold_n  = HOLD_ONE;
            end else begin
              state_n = IDLE;
              valid_n = 1'b0;
              oh_n    = 16'd0;
              hold_n  = '0;
            end
          end
          default: begin
            if (hold_cnt != HOLD_MAX) begin
              hold_n = hold_cnt + HOLD_ONE;
            end
          end
        endcase
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
        oh_n    = 16'd0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= 4'd0;
      hold_cnt   <= '0;
      gnt_valid  <= 1'b0;
      gnt_idx    <= 4'd0;
      gnt_onehot <= 16'd0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      hold_cnt   <= hold_n;
      gnt_valid  <= valid_n;
      gnt_idx    <= idx_n;
      gnt_onehot <= oh_n;
      timeout    <= to_n;
    end
  end

endmodule
